// File: rtl/i2s_rx_pkg.sv
// Shared types and constants for the I2S receiver: slot-tracking states,
// word geometry, default tuning values and the slot bit-placement helper.
package i2s_rx_pkg;

    localparam int WORD_W              = 32;
    localparam int CNT_W               = 6;
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int DEFAULT_TIMEOUT     = 256;

    // A count of 33 marks a slot that carried more bits than a word holds
    localparam logic [CNT_W-1:0] CNT_SAT = 6'd33;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } rx_state_t;

    // Sets bit n of a slot (n = 0 is the MSB) at word position 31-n
    function automatic logic [WORD_W-1:0] place_bit(
        input logic [WORD_W-1:0] word,
        input logic [CNT_W-1:0]  cnt,
        input logic              sd
    );
        logic [WORD_W-1:0] v_word;
        logic [4:0]        v_pos;
        v_word = word;
        v_pos  = 5'd31 - cnt[4:0];
        if (sd && (cnt < 6'd32)) begin
            v_word[v_pos] = 1'b1;
        end else begin
            v_word = word;
        end
        return v_word;
    endfunction

endpackage

// File: rtl/i2s_sync_receiver_pin_synchroniser.sv
// Flip-flop synchroniser for one asynchronous I2S pin, plus a rising-edge
// strobe built from the last two synchronised samples.
module pin_synchroniser
    import i2s_rx_pkg::*;
#(
    parameter int STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_sync,
    output logic o_rise
);

    logic [STAGES-1:0] r_chain;
    logic              r_prev;

    // Shift the pin through the synchroniser chain and remember the last output
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
            r_prev  <= 1'b0;
        end else begin
            r_chain[0] <= i_pin;
            for (int i = 1; i < STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
            r_prev <= r_chain[STAGES-1];
        end
    end

    assign o_sync = r_chain[STAGES-1];
    assign o_rise = r_chain[STAGES-1] & ~r_prev;

endmodule

// File: rtl/i2s_sync_receiver.sv
// I2S receiver: synchronises the bus pins, assembles left/right slots and
// hands matched stereo pairs to a valid/ready consumer.
module i2s_sync_receiver
    import i2s_rx_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i2s_bclk,
    input  logic              i2s_fclk,
    input  logic              i2s_data,
    output logic [WORD_W-1:0] data_left,
    output logic [WORD_W-1:0] data_right,
    output logic              valid,
    input  logic              ready,
    output logic              locked,
    output logic              overrun,
    output logic              frame_error
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic w_bclk_rise, w_ws, w_sd;
    logic w_unused_bclk_sync, w_unused_ws_rise, w_unused_sd_rise;

    pin_synchroniser #(.STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk(clk), .rst(rst), .i_pin(i2s_bclk), .o_sync(w_unused_bclk_sync), .o_rise(w_bclk_rise)
    );
    pin_synchroniser #(.STAGES(SYNC_STAGES)) u_sync_ws (
        .clk(clk), .rst(rst), .i_pin(i2s_fclk), .o_sync(w_ws), .o_rise(w_unused_ws_rise)
    );
    pin_synchroniser #(.STAGES(SYNC_STAGES)) u_sync_sd (
        .clk(clk), .rst(rst), .i_pin(i2s_data), .o_sync(w_sd), .o_rise(w_unused_sd_rise)
    );

    logic              r_smp_v, r_smp_ws, r_smp_sd, r_ws_prev;
    rx_state_t         r_state;
    logic [WORD_W-1:0] r_shreg, r_left_word, r_data_left, r_data_right;
    logic [CNT_W-1:0]  r_cnt, r_left_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_valid, r_locked, r_overrun, r_frame_error;

    // Capture word select and data on each synchronised bclk rising edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_smp_v  <= 1'b0;
            r_smp_ws <= 1'b0;
            r_smp_sd <= 1'b0;
        end else begin
            r_smp_v <= w_bclk_rise;
            if (w_bclk_rise) begin
                r_smp_ws <= w_ws;
                r_smp_sd <= w_sd;
            end
        end
    end

    // The bit sampled on a ws change still belongs to the slot that is ending
    logic              w_boundary, w_pair_done, w_pair_ok, w_timeout, w_xfer;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [WORD_W-1:0] w_word_next;

    assign w_boundary  = r_smp_v && (r_smp_ws != r_ws_prev);
    assign w_cnt_next  = (r_cnt == CNT_SAT) ? CNT_SAT : r_cnt + 6'd1;
    assign w_word_next = place_bit(r_shreg, r_cnt, r_smp_sd);
    assign w_pair_done = w_boundary && (r_state == RIGHT) && !r_smp_ws;
    assign w_pair_ok   = w_pair_done && (r_left_cnt == w_cnt_next);
    assign w_timeout   = !r_smp_v && (r_to_cnt == TO_W'(TIMEOUT - 1));
    assign w_xfer      = r_valid && ready;

    // Slot FSM, loss-of-lock timer and output handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_ws_prev     <= 1'b0;
            r_shreg       <= '0;
            r_cnt         <= '0;
            r_left_word   <= '0;
            r_left_cnt    <= '0;
            r_to_cnt      <= '0;
            r_data_left   <= '0;
            r_data_right  <= '0;
            r_valid       <= 1'b0;
            r_locked      <= 1'b0;
            r_overrun     <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_frame_error <= w_pair_done && !w_pair_ok;

            if (w_pair_ok && (!r_valid || ready)) begin
                r_data_left  <= r_left_word;
                r_data_right <= w_word_next;
                r_valid      <= 1'b1;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end

            // A held pair is never overwritten; the newcomer is lost instead
            if (w_pair_ok && r_valid && !ready) begin
                r_overrun <= 1'b1;
            end

            if (w_pair_ok) begin
                r_locked <= 1'b1;
            end else if (w_timeout) begin
                r_locked <= 1'b0;
            end

            if (r_smp_v) begin
                r_to_cnt  <= '0;
                r_ws_prev <= r_smp_ws;
                if (w_boundary) begin
                    r_shreg <= '0;
                    r_cnt   <= '0;
                    case (r_state)
                        IDLE: begin
                            if (!r_smp_ws) r_state <= LEFT;
                        end
                        LEFT: begin
                            if (r_smp_ws) begin
                                r_state     <= RIGHT;
                                r_left_word <= w_word_next;
                                r_left_cnt  <= w_cnt_next;
                            end
                        end
                        RIGHT: begin
                            if (!r_smp_ws) r_state <= LEFT;
                        end
                        default: r_state <= IDLE;
                    endcase
                end else begin
                    r_shreg <= w_word_next;
                    r_cnt   <= w_cnt_next;
                end
            end else if (w_timeout) begin
                r_to_cnt <= '0;
                r_state  <= IDLE;
                r_shreg  <= '0;
                r_cnt    <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
        end
    end

    assign data_left   = r_data_left;
    assign data_right  = r_data_right;
    assign valid       = r_valid;
    assign locked      = r_locked;
    assign overrun     = r_overrun;
    assign frame_error = r_frame_error;

endmodule

// File: tb/tb_i2s_sync_receiver.sv
// Self-checking bench: drives I2S frames with random data/timing and compares
// every output, every cycle, against a slot-level behavioural model.
module tb_i2s_sync_receiver;

    localparam int SS  = 2;
    localparam int TO  = 256;
    localparam int LAT = SS + 2;

    logic        clk = 1'b0;
    logic        rst, bclk, fclk, sdata, ready;
    logic [31:0] data_left, data_right;
    logic        valid, locked, overrun, frame_error;

    i2s_sync_receiver #(.SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .i2s_bclk(bclk), .i2s_fclk(fclk), .i2s_data(sdata),
        .data_left(data_left), .data_right(data_right), .valid(valid), .ready(ready),
        .locked(locked), .overrun(overrun), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0, half = 3, end_rise_cyc = 0, vrise_cyc = -1, vcount = 0, fcount = 0;
    bit rand_ready = 1'b0;
    logic prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [2:0]  m_pipe[$];           // {rise, ws, sd} seen by the core SS+1 edges later
    bit          m_bits[$];           // bits of the slot in progress, MSB first
    logic        m_prev_bclk, m_ws_prev, m_valid, m_locked, m_ovr, m_ferr;
    logic [31:0] m_L, m_R, m_lw;
    int          m_phase, m_quiet, m_ln;   // phase: 0 idle, 1 left, 2 right

    function automatic logic [31:0] pack_bits();
        logic [31:0] w = 32'h0;
        for (int n = 0; n < m_bits.size() && n < 32; n++) w[31-n] = m_bits[n];
        return w;
    endfunction

    task automatic model_edge(input logic r_s, input logic b_s, input logic w_s,
                              input logic d_s, input logic y_s);
        logic [2:0]  cur;
        logic [31:0] rw;
        int          rn;
        bit          done, ok;
        if (r_s) begin
            m_pipe.delete();
            repeat (SS + 1) m_pipe.push_back(3'b000);
            m_bits.delete();
            m_prev_bclk = 1'b0; m_ws_prev = 1'b0; m_valid = 1'b0; m_locked = 1'b0;
            m_ovr = 1'b0; m_ferr = 1'b0; m_L = 32'h0; m_R = 32'h0; m_lw = 32'h0;
            m_phase = 0; m_quiet = 0; m_ln = 0;
        end else begin
            m_pipe.push_back({b_s & ~m_prev_bclk, w_s, d_s});
            m_prev_bclk = b_s;
            cur = m_pipe.pop_front();
            done = 1'b0; rw = 32'h0; rn = 0;
            if (cur[2]) begin
                m_quiet = 0;
                m_bits.push_back(cur[0]);
                if (cur[1] != m_ws_prev) begin
                    if (m_phase == 0 && !cur[1]) m_phase = 1;
                    else if (m_phase == 1 && cur[1]) begin
                        m_lw = pack_bits(); m_ln = (m_bits.size() > 33) ? 33 : m_bits.size();
                        m_phase = 2;
                    end else if (m_phase == 2 && !cur[1]) begin
                        rw = pack_bits(); rn = (m_bits.size() > 33) ? 33 : m_bits.size();
                        done = 1'b1; m_phase = 1;
                    end
                    m_bits.delete();
                end
                m_ws_prev = cur[1];
            end else begin
                m_quiet++;
                if (m_quiet == TO) begin
                    m_quiet = 0; m_locked = 1'b0; m_phase = 0; m_bits.delete();
                end
            end
            ok = done && (rn == m_ln);
            m_ferr = done && !ok;
            if (ok) begin
                m_locked = 1'b1;
                if (!m_valid || y_s) begin m_L = m_lw; m_R = rw; m_valid = 1'b1; end
                else m_ovr = 1'b1;
            end else if (m_valid && y_s) m_valid = 1'b0;
        end
    endtask

    // Model update on each edge, then compare all outputs just after it
    initial begin : model_check
        forever begin
            @(posedge clk);
            cyc++;
            model_edge(rst, bclk, fclk, sdata, ready);
            #1;
            chk("valid", {31'h0, valid}, {31'h0, m_valid});
            chk("data_left", data_left, m_L);
            chk("data_right", data_right, m_R);
            chk("locked", {31'h0, locked}, {31'h0, m_locked});
            chk("overrun", {31'h0, overrun}, {31'h0, m_ovr});
            chk("frame_error", {31'h0, frame_error}, {31'h0, m_ferr});
            if (valid && !prev_valid) vrise_cyc = cyc;
            if (valid) vcount++;
            if (frame_error) fcount++;
            prev_valid = valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        if (rand_ready) ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_bit(input logic ws, input logic sd, input bit mark);
        bclk = 1'b0; fclk = ws; sdata = sd;
        repeat (half) tick();
        bclk = 1'b1;
        if (mark) end_rise_cyc = cyc;
        repeat (half) tick();
    endtask

    // Last bit of a slot is clocked with the next slot's word select
    task automatic send_slot(input logic ws_own, input logic ws_next, input logic [31:0] word,
                             input int n, input bit mark_last);
        for (int j = 0; j < n; j++)
            send_bit((j == n - 1) ? ws_next : ws_own,
                     (j < 32) ? word[31-j] : 1'($urandom_range(0, 1)),
                     mark_last && (j == n - 1));
    endtask

    task automatic send_frame(input logic [31:0] l, input int nl, input logic [31:0] r, input int nr);
        send_slot(1'b0, 1'b1, l, nl, 1'b0);
        send_slot(1'b1, 1'b0, r, nr, 1'b1);
    endtask

    initial begin : stim
        logic [31:0] l, r, mask;
        int n, v0, f0;
        rst = 1'b1; bclk = 1'b0; fclk = 1'b0; sdata = 1'b0; ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'h0, valid}, 32'h0);
        chk("rst_left", data_left, 32'h0);
        chk("rst_locked", {31'h0, locked}, 32'h0);
        rst = 1'b0;

        // Partial frame while idle, then one full 32-bit frame
        v0 = vcount;
        send_slot(1'b0, 1'b1, $urandom, 8, 1'b0);
        send_slot(1'b1, 1'b0, $urandom, 32, 1'b0);
        idle(8);
        chk("partial_suppressed", vcount - v0, 32'd0);
        send_frame(32'hA5A50001, 32, 32'h5A5A8000, 32);
        idle(10);
        chk("l32", data_left, 32'hA5A50001);
        chk("r32", data_right, 32'h5A5A8000);
        chk("model_l32", m_L, 32'hA5A50001);
        chk("one_pulse", vcount - v0, 32'd1);
        chk("locked_first", {31'h0, locked}, 32'h1);
        chk("latency", vrise_cyc - end_rise_cyc, LAT);

        // 24-bit slots are left-justified with zero fill
        send_frame(32'h12345600, 24, 32'hABCDEF00, 24);
        idle(10);
        chk("l24", data_left, 32'h12345600);
        chk("r24", data_right, 32'hABCDEF00);
        chk("model_r24", m_R, 32'hABCDEF00);

        // Random lengths (34 exercises counter saturation) and bit timing
        for (int k = 0; k < 5; k++) begin
            l = $urandom; r = $urandom;
            n = (k == 4) ? 34 : $urandom_range(8, 32);
            half = $urandom_range(2, 4);
            send_frame(l, n, r, n);
            idle($urandom_range(6, 20));
            mask = (n >= 32) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> n);
            chk("rand_left", data_left, l & mask);
            chk("rand_right", data_right, r & mask);
        end
        half = 3;

        // Back-pressure over two pairs: first held, second dropped
        ready = 1'b0;
        send_frame(32'h11112222, 32, 32'h33334444, 32);
        idle(6);
        send_frame(32'h55556666, 32, 32'h77778888, 32);
        idle(10);
        chk("held_left", data_left, 32'h11112222);
        chk("held_right", data_right, 32'h33334444);
        chk("held_valid", {31'h0, valid}, 32'h1);
        chk("overrun_set", {31'h0, overrun}, 32'h1);
        ready = 1'b1;
        idle(2);
        chk("xfer_valid_low", {31'h0, valid}, 32'h0);
        chk("overrun_sticky", {31'h0, overrun}, 32'h1);

        // Mismatched slot lengths give a single frame_error and no pair
        v0 = vcount; f0 = fcount;
        send_frame($urandom, 32, $urandom, 24);
        idle(10);
        chk("ferr_pulse", fcount - f0, 32'd1);
        chk("ferr_no_valid", vcount - v0, 32'd0);

        // Random ready against random frames
        rand_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(16, 32);
            half = $urandom_range(2, 4);
            send_frame($urandom, n, $urandom, n);
            idle($urandom_range(0, 12));
        end
        rand_ready = 1'b0; ready = 1'b1; half = 3;
        idle(10);

        // bclk stalls mid-slot longer than the timeout
        send_slot(1'b0, 1'b0, $urandom, 10, 1'b0);
        idle(300);
        chk("timeout_unlock", {31'h0, locked}, 32'h0);
        send_slot(1'b0, 1'b1, $urandom, 8, 1'b0);
        send_slot(1'b1, 1'b0, $urandom, 32, 1'b0);
        idle(8);
        chk("no_relock_early", {31'h0, locked}, 32'h0);
        send_frame(32'hCAFE0123, 32, 32'h0BADF00D, 32);
        idle(10);
        chk("relock", {31'h0, locked}, 32'h1);
        chk("relock_left", data_left, 32'hCAFE0123);

        // Reset in the middle of a right slot
        send_slot(1'b0, 1'b1, $urandom, 32, 1'b0);
        send_slot(1'b1, 1'b1, $urandom, 10, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_left", data_left, 32'h0);
        chk("mid_rst_right", data_right, 32'h0);
        chk("mid_rst_flags", {28'h0, valid, locked, overrun, frame_error}, 32'h0);
        v0 = vcount;
        send_slot(1'b1, 1'b0, $urandom, 22, 1'b0);
        idle(8);
        chk("no_stale_pair", vcount - v0, 32'd0);
        send_frame(32'h89ABCDEF, 32, 32'h01234567, 32);
        idle(10);
        chk("post_rst_pair", vcount - v0, 32'd1);
        chk("post_rst_right", data_right, 32'h01234567);
        chk("post_rst_locked", {31'h0, locked}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2s_sync_receiver.md
I2S_SYNC_RECEIVER -- requirements
Module: i2s_sync_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of flip-flop synchroniser stages on each I2S pin.
REQ-002 SHALL have parameter TIMEOUT, default 256: number of clk cycles without a bclk rising edge before the block declares loss of lock.
REQ-003 SHALL have port clk, input, 1 bit: single system clock, at least 4x the bclk frequency.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port i2s_bclk, input, 1 bit: asynchronous I2S bit clock.
REQ-006 SHALL have port i2s_fclk, input, 1 bit: asynchronous word select (0 = left, 1 = right).
REQ-007 SHALL have port i2s_data, input, 1 bit: asynchronous serial data, MSB first, standard I2S one-bit delay.
REQ-008 SHALL have port data_left, output, 32 bits: left sample, left-justified.
REQ-009 SHALL have port data_right, output, 32 bits: right sample, left-justified.
REQ-010 SHALL have port valid, output, 1 bit: a stereo pair is held on data_left/data_right.
REQ-011 SHALL have port ready, input, 1 bit: the downstream FIFO accepts the pair.
REQ-012 SHALL have port locked, output, 1 bit: the receiver is frame-aligned.
REQ-013 SHALL have port overrun, output, 1 bit: sticky flag; a pair was dropped.
REQ-014 SHALL have port frame_error, output, 1 bit: one-cycle pulse; a pair was rejected.

Function
REQ-015 SHALL pass i2s_bclk, i2s_fclk and i2s_data through SYNC_STAGES flip-flops each, then detect a bclk rising edge as (current synchronised bclk = 1) and (previous synchronised bclk = 0).
REQ-016 SHALL, only in a rising-edge cycle, sample synchronised i2s_fclk and i2s_data, and keep the previous ws sample (ws_prev).
REQ-017 SHALL treat a rising edge where ws != ws_prev as a slot boundary: the sd bit sampled on that edge is the LSB of the ending slot, and the next edge carries the MSB of the new slot.
REQ-018 SHALL store bit n of a slot (n = 0 for the MSB) at position 31-n of the word.
REQ-019 SHALL saturate the slot bit counter at 33, discard bits beyond the 32nd, zero-fill unreceived low bits, and clear the shift register at each slot start.
REQ-020 SHALL implement state machine IDLE -> LEFT -> RIGHT -> LEFT.
REQ-021 SHALL leave IDLE only at a ws 1->0 boundary, without emitting any partial slot.
REQ-022 SHALL go LEFT -> RIGHT at a ws 0->1 boundary, latching the left word and left bit count.
REQ-023 SHALL go RIGHT -> LEFT at a ws 1->0 boundary, completing the pair.
REQ-024 SHALL, on pair completion with equal left and right bit counts, load the output registers and assert valid on the next clk.
REQ-025 SHALL, on pair completion with unequal bit counts, drop the pair and pulse frame_error for one cycle.
REQ-026 SHALL keep data_left and data_right stable while valid=1 and ready=0; a transfer occurs when valid=1 and ready=1.
REQ-027 SHALL, when a pair completes while valid=1 and ready=0, drop the new pair, keep the held pair, and set overrun until rst.
REQ-028 SHALL, when a pair completes in the same cycle as a transfer, load the new pair and keep valid=1.
REQ-029 SHALL deassert valid on a transfer when no new pair completes in that cycle.
REQ-030 SHALL set locked=1 when the first pair is emitted after leaving IDLE.
REQ-031 SHALL, after TIMEOUT consecutive clk cycles without a bclk rising edge, clear locked, discard any partial slot and return to IDLE; a pending valid pair is kept.
REQ-032 SHALL have a latency of SYNC_STAGES+2 clk cycles from the i2s_bclk pin edge that ends the right slot to valid=1.

Reset
REQ-033 SHALL, on rst=1 at a clk edge, clear synchronisers, shift register, counters and timeout counter, enter IDLE, and drive data_left=0, data_right=0, valid=0, locked=0, overrun=0, frame_error=0.
REQ-034 SHALL, when rst is asserted mid-slot, emit no pair afterwards that is derived from pre-reset bits.

Structure
REQ-035 SHALL take the state enum (IDLE, LEFT, RIGHT), word width 32 and the default constants from shared package i2s_rx_pkg.
REQ-036 SHALL instantiate one sub-module, pin_synchroniser (SYNC_STAGES flip-flop chain plus rising-edge detect), once per I2S pin.

Verification
REQ-037 SHALL cover: reset, then 32-bit slots with L=0xA5A50001, R=0x5A5A8000, ready=1 -> first partial frame suppressed, then a single one-cycle valid pulse with those values and locked=1.
REQ-038 SHALL cover: 24-bit slots with L=0x123456, R=0xABCDEF -> data_left=0x12345600, data_right=0xABCDEF00.
REQ-039 SHALL cover: ready=0 over two completed pairs -> first pair held stable, second dropped, overrun=1 sticky; then ready=1 -> first pair transferred and valid=0.
REQ-040 SHALL cover: left slot 32 bits, right slot 24 bits -> frame_error pulse of 1 cycle and no valid.
REQ-041 SHALL cover: bclk stopped 300 clk cycles with TIMEOUT=256 -> locked=0 and partial slot discarded; on restart, relock after the next complete pair.
REQ-042 SHALL cover: rst pulsed mid right slot -> all outputs 0 on the next clk and no pair emitted until a full new frame completes.
